// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks (receiver now, transmitter later).
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;

   // Ticks within a bit at which the line is sampled for the majority vote.
   localparam logic [3:0] SAMPLE_A    = 4'd7;
   localparam logic [3:0] SAMPLE_B    = 4'd8;
   localparam logic [3:0] SAMPLE_C    = 4'd9;
   localparam logic [3:0] SAMPLE_LAST = 4'd15;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } uart_state_t;

   // Clocks per oversample tick, floored; callers must keep the result >= 2.
   function automatic int uart_div(input int clkHz, input int baud);
      return clkHz / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received-byte strobe and status out, between the receiver and its consumer.
interface uart_rx_if;
   import uart_pkg::*;

   logic                 i_rx;
   logic                 o_rx_receive;
   logic [DATA_BITS-1:0] o_rx_data;
   logic                 o_frame_err;
   logic                 o_busy;

   modport master (
      input  i_rx,
      output o_rx_receive,
      output o_rx_data,
      output o_frame_err,
      output o_busy
   );

   modport slave (
      input  i_rx,
      input  o_rx_receive,
      input  o_rx_data,
      input  o_frame_err,
      input  o_busy
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: one-cycle tick every DIV clocks, restartable by a synchronous clear.
module uart_baud_tick #(
   parameter int DIV = 651
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   output logic o_tick
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_count;

   assign o_tick = (r_count == LAST);

   // Free-running modulo-DIV counter; clear restarts the phase at zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_count <= '0;
      else if (i_clear || o_tick)
         r_count <= '0;
      else
         r_count <= r_count + 1'b1;
   end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver with 16x oversampling, 2-of-3 mid-bit vote and framing-error strobe.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 9600
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   uart_rx_if.master bus
);

   localparam int DIV = uart_div(CLK_HZ, BAUD);

   uart_state_t r_state;
   uart_state_t w_stateNext;

   logic       r_rxMeta;
   logic       r_rxSync;
   logic       w_rxS;
   logic       w_tick;
   logic       w_clear;
   logic [3:0] r_s;
   logic       r_v7;
   logic       r_v8;
   logic       r_v9;
   logic       w_third;
   logic       w_bitVal;
   logic [2:0] r_bitIdx;
   logic [7:0] r_shreg;
   logic [7:0] r_rxData;
   logic       r_rxReceive;
   logic       r_frameErr;
   logic       w_shift;
   logic       w_receive;
   logic       w_frameErr;

   assign w_rxS = r_rxSync;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (w_clear),
      .o_tick  (w_tick)
   );

   // Two-flop synchroniser for the asynchronous serial line; idles high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rxMeta <= 1'b1;
         r_rxSync <= 1'b1;
      end else begin
         r_rxMeta <= bus.i_rx;
         r_rxSync <= r_rxMeta;
      end
   end

   // Tick position within the current bit; held at zero while idle so each frame restarts aligned.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_s <= '0;
      else if (r_state == IDLE)
         r_s <= '0;
      else if (w_tick)
         r_s <= r_s + 4'd1;
   end

   // Capture the line at the three mid-bit ticks for the majority vote.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v7 <= 1'b1;
         r_v8 <= 1'b1;
         r_v9 <= 1'b1;
      end else if (w_tick && r_state != IDLE) begin
         if (r_s == SAMPLE_A) r_v7 <= w_rxS;
         if (r_s == SAMPLE_B) r_v8 <= w_rxS;
         if (r_s == SAMPLE_C) r_v9 <= w_rxS;
      end
   end

   // At the third sample tick the newest sample is still on the line, not yet in r_v9.
   assign w_third  = (r_s == SAMPLE_C) ? w_rxS : r_v9;
   assign w_bitVal = (r_v7 & r_v8) | (r_v7 & w_third) | (r_v8 & w_third);

   // Receive shift register, LSB first, plus the data bit index.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shreg  <= '0;
         r_bitIdx <= '0;
      end else if (r_state == START) begin
         r_bitIdx <= '0;
      end else if (w_shift) begin
         r_shreg  <= {w_bitVal, r_shreg[7:1]};
         r_bitIdx <= r_bitIdx + 3'd1;
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= IDLE;
      else
         r_state <= w_stateNext;
   end

   // Next-state and per-cycle control decisions.
   always_comb begin
      w_stateNext = r_state;
      w_clear     = 1'b0;
      w_shift     = 1'b0;
      w_receive   = 1'b0;
      w_frameErr  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_rxS) begin
               w_stateNext = START;
               w_clear     = 1'b1;
            end
         end
         START: begin
            if (w_tick && r_s == SAMPLE_C && w_bitVal)
               w_stateNext = IDLE;
            else if (w_tick && r_s == SAMPLE_LAST)
               w_stateNext = DATA;
         end
         DATA: begin
            if (w_tick && r_s == SAMPLE_LAST) begin
               w_shift = 1'b1;
               if (r_bitIdx == 3'd7)
                  w_stateNext = STOP;
            end
         end
         STOP: begin
            if (w_tick && r_s == SAMPLE_C) begin
               if (w_bitVal) begin
                  w_receive   = 1'b1;
                  w_stateNext = IDLE;
               end else begin
                  w_frameErr  = 1'b1;
                  w_stateNext = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (w_rxS)
               w_stateNext = IDLE;
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // Registered output strobes and the held data byte.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rxReceive <= 1'b0;
         r_frameErr  <= 1'b0;
         r_rxData    <= '0;
      end else begin
         r_rxReceive <= w_receive;
         r_frameErr  <= w_frameErr;
         if (w_receive)
            r_rxData <= r_shreg;
      end
   end

   assign bus.o_rx_receive = r_rxReceive;
   assign bus.o_frame_err  = r_frameErr;
   assign bus.o_rx_data    = r_rxData;
   assign bus.o_busy       = (r_state != IDLE);

endmodule
